tl_inflight_monitor: RTL and testbench

TL_INFLIGHT_MONITOR -- requirements
Module: tl_inflight_monitor

---
 rtl/tl_inflight_monitor_if.sv | 32 +++
 rtl/tl_inflight_monitor.sv | 255 +++++++++++++++++++++++++
 tb/tb_tl_inflight_monitor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/tl_inflight_monitor_if.sv
// TileLink-UL A/D channel bundle watched by tl_inflight_monitor.
// master drives A and d_ready, slave drives D and a_ready, and the monitor only observes.
interface tl_inflight_monitor_if #(
  parameter int SRC_W = 2
);
  logic             a_valid;
  logic             a_ready;
  logic [2:0]       a_opcode;
  logic [2:0]       a_size;
  logic [SRC_W-1:0] a_source;
  logic [31:0]      a_address;
  logic             d_valid;
  logic             d_ready;
  logic [2:0]       d_opcode;
  logic [2:0]       d_size;
  logic [SRC_W-1:0] d_source;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_source
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source
  );

  modport monitor (
    input a_valid, a_ready, a_opcode, a_size, a_source, a_address,
          d_valid, d_ready, d_opcode, d_size, d_source
  );
endinterface

// File: rtl/tl_inflight_monitor.sv
// Passive TileLink-UL monitor: tracks outstanding sources, checks responses,
// handshake stability, stalls and alignment, and latches the first error code.
// Optional macro TL_MON_PRINTF_EN prints each latched error in simulation.

// One tracked source: the inflight bit plus the opcode/size its request carried.
module tl_inflight_monitor_slot (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       set,
  input  logic       clr,
  input  logic [2:0] op_in,
  input  logic [2:0] size_in,
  output logic       inflight,
  output logic       inflight_nx,
  output logic [2:0] op,
  output logic [2:0] size
);
  // A new request wins over a same-cycle final response, so the bit stays set.
  assign inflight_nx = set | (inflight & ~clr);

  // Hold the inflight state and capture the request attributes on a first A beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
      op       <= '0;
      size     <= '0;
    end else begin
      inflight <= inflight_nx;
      if (set) begin
        op   <= op_in;
        size <= size_in;
      end
    end
  end
endmodule

module tl_inflight_monitor #(
  parameter int SRC_W      = 2,
  parameter int BEAT_BYTES = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clock,
  input  logic                  reset_n,
  tl_inflight_monitor_if.monitor bus,
  output logic                  err_valid,
  output logic [3:0]            err_code,
  output logic [SRC_W:0]        inflight_cnt
);
  localparam int NSRC   = 1 << SRC_W;
  localparam int LOG_BB = $clog2(BEAT_BYTES);
  localparam int TCW    = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       size;
    logic [SRC_W-1:0] source;
    logic [31:0]      address;
  } a_bits_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       size;
    logic [SRC_W-1:0] source;
  } d_bits_t;

  // Beats in a burst of 2^size bytes; sub-beat transfers still take one beat.
  function automatic logic [7:0] beats_of(input logic [2:0] size);
    if (int'(size) >= LOG_BB) return 8'd1 << (int'(size) - LOG_BB);
    else                      return 8'd1;
  endfunction

  a_bits_t a_bits, a_bits_q;
  d_bits_t d_bits, d_bits_q;

  assign a_bits = {bus.a_opcode, bus.a_size, bus.a_source, bus.a_address};
  assign d_bits = {bus.d_opcode, bus.d_size, bus.d_source};

  logic a_fire, d_fire, a_stall, d_stall;
  assign a_fire  = bus.a_valid & bus.a_ready;
  assign d_fire  = bus.d_valid & bus.d_ready;
  assign a_stall = bus.a_valid & ~bus.a_ready;
  assign d_stall = bus.d_valid & ~bus.d_ready;

  // ---- per-source tracking ----
  logic [NSRC-1:0]       a_set, d_clr, inflight, inflight_nx;
  logic [NSRC-1:0][2:0]  rec_op, rec_size;

  for (genvar g = 0; g < NSRC; g++) begin : g_slot
    tl_inflight_monitor_slot u_slot (
      .clock       (clock),
      .reset_n     (reset_n),
      .set         (a_set[g]),
      .clr         (d_clr[g]),
      .op_in       (a_bits.opcode),
      .size_in     (a_bits.size),
      .inflight    (inflight[g]),
      .inflight_nx (inflight_nx[g]),
      .op          (rec_op[g]),
      .size        (rec_size[g])
    );
  end

  // ---- beat accounting ----
  logic [7:0] a_beat, d_beat, a_total, d_total;
  logic       a_first, a_last, d_last;
  logic       a_is_put, d_inflight, d_multi;
  logic [2:0] d_rec_op, d_rec_size;

  assign a_is_put   = (a_bits.opcode == OP_PUT_FULL) | (a_bits.opcode == OP_PUT_PART);
  assign a_total    = a_is_put ? beats_of(a_bits.size) : 8'd1;
  assign a_first    = (a_beat == 8'd0);
  assign a_last     = ((a_beat + 8'd1) >= a_total);

  assign d_inflight = inflight[d_bits.source];
  assign d_rec_op   = rec_op[d_bits.source];
  assign d_rec_size = rec_size[d_bits.source];
  // Burst length follows the request we recorded; a stray beat falls back on its own opcode.
  assign d_multi    = d_inflight ? (d_rec_op == OP_GET) : (d_bits.opcode == OP_ACK_DATA);
  assign d_total    = d_multi ? beats_of(d_bits.size) : 8'd1;
  assign d_last     = ((d_beat + 8'd1) >= d_total);

  // Decode which slot a first A beat sets and which one a last D beat clears
  always_comb begin
    a_set = '0;
    d_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      a_set[i] = a_fire & a_first & (a_bits.source == SRC_W'(i));
      d_clr[i] = d_fire & d_last  & (d_bits.source == SRC_W'(i));
    end
  end

  // Walk each channel's beat counter through a burst and wrap to 0 after the last beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_beat <= '0;
      d_beat <= '0;
    end else begin
      if (a_fire) a_beat <= a_last ? 8'd0 : a_beat + 8'd1;
      if (d_fire) d_beat <= d_last ? 8'd0 : d_beat + 8'd1;
    end
  end

  // ---- handshake hold tracking and stall counters ----
  logic           a_hold_q, d_hold_q;
  logic [TCW-1:0] a_to_cnt, d_to_cnt;

  // Remember last cycle's stall state and fields; count stalled cycles up to saturation
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_hold_q <= 1'b0;
      d_hold_q <= 1'b0;
      a_bits_q <= '0;
      d_bits_q <= '0;
      a_to_cnt <= '0;
      d_to_cnt <= '0;
    end else begin
      a_hold_q <= a_stall;
      d_hold_q <= d_stall;
      a_bits_q <= a_bits;
      d_bits_q <= d_bits;
      if (!a_stall)                        a_to_cnt <= '0;
      else if (a_to_cnt != TCW'(TIMEOUT))  a_to_cnt <= a_to_cnt + 1'b1;
      if (!d_stall)                        d_to_cnt <= '0;
      else if (d_to_cnt != TCW'(TIMEOUT))  d_to_cnt <= d_to_cnt + 1'b1;
    end
  end

  // ---- error detection; bit k stands for code k+1 ----
  logic [8:0] err_vec;
  logic       err_any;
  logic [3:0] err_code_nx;
  logic       same_src_close, d_op_bad, a_misalign;

  assign same_src_close = d_fire & d_last & (d_bits.source == a_bits.source);
  assign d_op_bad = ((d_rec_op == OP_GET) & (d_bits.opcode != OP_ACK_DATA)) |
                    (((d_rec_op == OP_PUT_FULL) | (d_rec_op == OP_PUT_PART)) &
                     (d_bits.opcode != OP_ACK));
  assign a_misalign = (a_bits.address & ((32'd1 << a_bits.size) - 32'd1)) != 32'd0;

  // Gather every check that trips this cycle
  always_comb begin
    err_vec    = '0;
    err_vec[0] = a_fire & a_first & inflight[a_bits.source] & ~same_src_close;
    err_vec[1] = d_fire & ~d_inflight;
    err_vec[2] = d_fire & d_inflight & d_op_bad;
    err_vec[3] = d_fire & d_inflight & (d_bits.size != d_rec_size);
    err_vec[4] = bus.a_valid & a_hold_q & (a_bits != a_bits_q);
    err_vec[5] = bus.d_valid & d_hold_q & (d_bits != d_bits_q);
    err_vec[6] = a_stall & (a_to_cnt == TCW'(TIMEOUT - 1));
    err_vec[7] = d_stall & (d_to_cnt == TCW'(TIMEOUT - 1));
    err_vec[8] = a_fire & a_first & a_misalign;
  end

  // Lowest-numbered code wins when several fire together
  always_comb begin
    err_code_nx = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (err_vec[i]) err_code_nx = 4'(i + 1);
    end
  end

  assign err_any = |err_vec;

  // Registered popcount of the post-edge inflight bits
  logic [SRC_W:0] cnt_nx;
  always_comb begin
    cnt_nx = '0;
    for (int i = 0; i < NSRC; i++) cnt_nx = cnt_nx + (SRC_W+1)'(inflight_nx[i]);
  end

  // Latch the first error and keep it until reset; publish the inflight count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_valid    <= 1'b0;
      err_code     <= 4'd0;
      inflight_cnt <= '0;
    end else begin
      inflight_cnt <= cnt_nx;
      if (!err_valid && err_any) begin
        err_valid <= 1'b1;
        err_code  <= err_code_nx;
      end
    end
  end

`ifdef TL_MON_PRINTF_EN
`ifndef SYNTHESIS
  logic [31:0]      cyc_q;
  logic [SRC_W-1:0] err_src;
  // A-side codes report the A source, everything else the D source
  assign err_src = (err_code_nx == 4'd1 || err_code_nx == 4'd5 ||
                    err_code_nx == 4'd7 || err_code_nx == 4'd9) ? a_bits.source : d_bits.source;

  // Count cycles and print the error that is about to be latched
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (!err_valid && err_any)
        $display("[tl_mon] cycle %0d: error code %0d source %0d",
                 cyc_q, err_code_nx, err_src);
    end
  end
`endif
`else
  // Silent build: no diagnostic output, detection and outputs are unchanged.
`endif
endmodule

// File: tb/tb_tl_inflight_monitor.sv
// Directed bench for tl_inflight_monitor with hand-computed expectations.
module tb_tl_inflight_monitor;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       err_valid;
  logic [3:0] err_code;
  logic [2:0] inflight_cnt;
  int tests = 0;
  int fails = 0;

  tl_inflight_monitor_if #(.SRC_W(2)) bus ();

  tl_inflight_monitor #(.SRC_W(2), .BEAT_BYTES(4), .TIMEOUT(256)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .inflight_cnt (inflight_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic idle();
    bus.a_valid = 1'b0; bus.a_ready = 1'b1; bus.a_opcode = 3'd0; bus.a_size = 3'd0;
    bus.a_source = 2'd0; bus.a_address = 32'd0;
    bus.d_valid = 1'b0; bus.d_ready = 1'b1; bus.d_opcode = 3'd0; bus.d_size = 3'd0;
    bus.d_source = 2'd0;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                         input logic [31:0] addr, input logic rdy);
    bus.a_valid = 1'b1; bus.a_ready = rdy; bus.a_opcode = op; bus.a_size = sz;
    bus.a_source = src; bus.a_address = addr;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                         input logic rdy);
    bus.d_valid = 1'b1; bus.d_ready = rdy; bus.d_opcode = op; bus.d_size = sz;
    bus.d_source = src;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called 1 time unit after an edge, so the pulse never overlaps a clock edge
  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("reset err_valid", 32'(err_valid), 32'd0);
    chk("reset err_code", 32'(err_code), 32'd0);
    chk("reset inflight_cnt", 32'(inflight_cnt), 32'd0);

    // Get src1 size2 then a single AccessAckData
    drive_a(3'd4, 3'd2, 2'd1, 32'h100, 1'b1);
    tick(); idle();
    chk("get1 cnt after A", 32'(inflight_cnt), 32'd1);
    drive_d(3'd1, 3'd2, 2'd1, 1'b1);
    tick(); idle();
    chk("get1 cnt after D", 32'(inflight_cnt), 32'd0);
    chk("get1 err_valid", 32'(err_valid), 32'd0);
    chk("get1 err_code", 32'(err_code), 32'd0);

    // Get src2 size4 = 4 D beats; the 3rd beat carries AccessAck
    drive_a(3'd4, 3'd4, 2'd2, 32'h200, 1'b1);
    tick(); idle();
    for (int b = 0; b < 4; b++) begin
      drive_d((b == 2) ? 3'd0 : 3'd1, 3'd4, 2'd2, 1'b1);
      tick();
      if (b == 1) chk("burst no err before beat3", 32'(err_valid), 32'd0);
      if (b == 2) begin
        chk("burst opcode err", 32'(err_code), 32'd3);
        chk("burst cnt mid", 32'(inflight_cnt), 32'd1);
      end
    end
    idle();
    chk("burst cnt end", 32'(inflight_cnt), 32'd0);
    chk("burst code sticky", 32'(err_code), 32'd3);

    // Duplicate request on src0 with no response
    do_reset();
    drive_a(3'd4, 3'd2, 2'd0, 32'h0, 1'b1);
    tick();
    tick(); idle();
    chk("dup src err", 32'(err_code), 32'd1);
    chk("dup src cnt", 32'(inflight_cnt), 32'd1);

    // Same, but the response for src0 closes in the same cycle as the second A
    do_reset();
    chk("after reset err_valid", 32'(err_valid), 32'd0);
    drive_a(3'd4, 3'd2, 2'd0, 32'h0, 1'b1);
    tick();
    drive_d(3'd1, 3'd2, 2'd0, 1'b1);
    tick(); idle();
    chk("reuse same cycle no err", 32'(err_valid), 32'd0);
    chk("reuse same cycle cnt", 32'(inflight_cnt), 32'd1);

    // Stray D (code 2) and misaligned A (code 9) together: lowest wins
    drive_a(3'd4, 3'd2, 2'd1, 32'h102, 1'b1);
    drive_d(3'd1, 3'd2, 2'd3, 1'b1);
    tick(); idle();
    chk("priority code", 32'(err_code), 32'd2);
    chk("priority cnt", 32'(inflight_cnt), 32'd2);
    // Size mismatch on src0 must not overwrite the first error
    drive_d(3'd1, 3'd3, 2'd0, 1'b1);
    tick(); idle();
    chk("first error kept", 32'(err_code), 32'd2);

    // Misaligned single-beat PutFull alone
    do_reset();
    drive_a(3'd0, 3'd2, 2'd1, 32'h6, 1'b1);
    tick(); idle();
    chk("misalign code", 32'(err_code), 32'd9);

    // Response size differs from the recorded request size
    do_reset();
    drive_a(3'd4, 3'd3, 2'd3, 32'h8, 1'b1);
    tick(); idle();
    drive_d(3'd1, 3'd2, 2'd3, 1'b1);
    tick(); idle();
    chk("size mismatch code", 32'(err_code), 32'd4);
    chk("size mismatch cnt", 32'(inflight_cnt), 32'd0);

    // A stalled for 256 cycles
    do_reset();
    drive_a(3'd4, 3'd2, 2'd0, 32'h0, 1'b0);
    repeat (255) tick();
    chk("a stall 255 quiet", 32'(err_valid), 32'd0);
    tick();
    chk("a stall timeout valid", 32'(err_valid), 32'd1);
    chk("a stall timeout code", 32'(err_code), 32'd7);
    idle();

    // A address changes while stalled
    do_reset();
    drive_a(3'd4, 3'd2, 2'd0, 32'h0, 1'b0);
    tick();
    tick();
    chk("a hold stable quiet", 32'(err_valid), 32'd0);
    bus.a_address = 32'h4;
    tick(); idle();
    chk("a hold change code", 32'(err_code), 32'd5);

    // D stalled for 256 cycles
    do_reset();
    drive_d(3'd1, 3'd2, 2'd0, 1'b0);
    repeat (256) tick();
    idle();
    chk("d stall timeout code", 32'(err_code), 32'd8);

    // Reset in the middle of a 2-beat PutFull, then a stray AccessAck
    do_reset();
    drive_a(3'd0, 3'd3, 2'd3, 32'h8, 1'b1);
    tick(); idle();
    chk("put first beat cnt", 32'(inflight_cnt), 32'd1);
    do_reset();
    chk("midburst reset cnt", 32'(inflight_cnt), 32'd0);
    chk("midburst reset err_valid", 32'(err_valid), 32'd0);
    drive_d(3'd0, 3'd3, 2'd3, 1'b1);
    tick(); idle();
    chk("stray ack valid", 32'(err_valid), 32'd1);
    chk("stray ack code", 32'(err_code), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
